// File: rtl/mtl_pkg.sv
// Shared types for the MTL mode scheduler.
// Mode codes, scheduler states and the legal-mode helper.
package mtl_pkg;

  typedef enum logic [3:0] {
    MODE_FIGHT  = 4'd0,
    MODE_LOAD   = 4'd1,
    MODE_MAP_P0 = 4'd2,
    MODE_MAP_P1 = 4'd3
  } mtl_mode_e;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_PENDING   = 3'd1,
    ST_FIGHT_ARM = 3'd2,
    ST_FIGHT_RUN = 3'd3,
    ST_REPORT    = 3'd4
  } mtl_state_e;

  localparam int FCNT_W = 11;

  function automatic logic is_legal_mode(input logic [3:0] code);
    return code < 4'd4;
  endfunction

endpackage

// File: rtl/mtl_frame_counter.sv
// Saturating iNewFrame counter with synchronous clear and terminal compares.
// Clear together with increment loads 1, so the clearing pulse itself counts.
module mtl_frame_counter
  import mtl_pkg::*;
#(
  parameter int W = FCNT_W
) (
  input  logic         iCLK,
  input  logic         iRST,
  input  logic         iClr,
  input  logic         iInc,
  input  logic [W-1:0] iTerm,
  output logic         oAtTerm,
  output logic         oHitTerm
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;
  logic [W-1:0] cnt_inc;

  always_comb begin
    cnt_inc = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;
    cnt_d   = cnt_q;
    if (iClr) begin
      cnt_d = iInc ? W'(1) : '0;
    end else if (iInc) begin
      cnt_d = cnt_inc;
    end
  end

  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // AtTerm: already there; HitTerm: this increment gets there
  assign oAtTerm  = (cnt_q == iTerm);
  assign oHitTerm = (cnt_inc == iTerm);

endmodule

// File: rtl/mtl_mode_scheduler.sv
// Host-side mode sequencer for mtl_controller: frame-aligned mode changes,
// fight arming/release, round timeout, result capture and interrupt.
module mtl_mode_scheduler
  import mtl_pkg::*;
#(
  parameter int ARM_FRAMES     = 2,
  parameter int TIMEOUT_FRAMES = 1800,
  parameter int CNT_W          = 32
) (
  input  logic             iCLK,
  input  logic             iRST,
  input  logic             iNewFrame,
  input  logic             iReqValid,
  output logic             oReqReady,
  input  logic [3:0]       iReqMode,
  output logic             oReqErr,
  output logic [3:0]       oMtlMode,
  output logic             oMtlReset,
  input  logic             iFightDone,
  input  logic [CNT_W-1:0] iFightCount,
  output logic [CNT_W-1:0] oResultTime,
  output logic             oTimeout,
  output logic             oIrq,
  input  logic             iIrqAck,
  output logic [2:0]       oState
);

  localparam logic [FCNT_W-1:0] ARM_T = FCNT_W'(ARM_FRAMES);
  localparam logic [FCNT_W-1:0] TMO_T = FCNT_W'(TIMEOUT_FRAMES);

  mtl_state_e       state_q, state_d;
  mtl_mode_e        pend_q, pend_d;
  mtl_mode_e        mode_q, mode_d;
  logic             mrst_q, mrst_d;
  logic             irq_q, irq_d;
  logic             tmo_q, tmo_d;
  logic [CNT_W-1:0] res_q, res_d;
  logic             err_q, err_d;

  logic              req_ready;
  logic              accept;
  logic              legal;
  logic              cnt_clr;
  logic              cnt_inc;
  logic [FCNT_W-1:0] cnt_term;
  logic              at_term;
  logic              hit_term;

  mtl_frame_counter #(
    .W (FCNT_W)
  ) u_frame_cnt (
    .iCLK     (iCLK),
    .iRST     (iRST),
    .iClr     (cnt_clr),
    .iInc     (cnt_inc),
    .iTerm    (cnt_term),
    .oAtTerm  (at_term),
    .oHitTerm (hit_term)
  );

  assign req_ready = (state_q == ST_IDLE) || (state_q == ST_FIGHT_RUN);
  assign accept    = iReqValid && req_ready;
  assign legal     = is_legal_mode(iReqMode);

  always_comb begin
    state_d  = state_q;
    pend_d   = pend_q;
    mode_d   = mode_q;
    mrst_d   = mrst_q;
    irq_d    = irq_q;
    tmo_d    = tmo_q;
    res_d    = res_q;
    err_d    = accept && !legal;
    cnt_clr  = 1'b1;
    cnt_inc  = 1'b0;
    cnt_term = TMO_T;

    unique case (state_q)
      ST_IDLE: begin
        if (accept && legal) begin
          pend_d  = mtl_mode_e'(iReqMode);
          state_d = ST_PENDING;
        end
      end

      ST_PENDING: begin
        if (iNewFrame) begin
          mode_d = pend_q;
          if (pend_q == MODE_FIGHT) begin
            cnt_inc = 1'b1;
            state_d = ST_FIGHT_ARM;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end

      ST_FIGHT_ARM: begin
        cnt_term = ARM_T;
        mrst_d   = 1'b1;
        cnt_clr  = iNewFrame && at_term;
        cnt_inc  = iNewFrame && !at_term;
        if (iNewFrame && at_term) begin
          mrst_d  = 1'b0;
          state_d = ST_FIGHT_RUN;
        end
      end

      ST_FIGHT_RUN: begin
        mrst_d  = 1'b0;
        cnt_clr = 1'b0;
        cnt_inc = iNewFrame;
        // A finished round outranks both timeout and a host abort
        if (iFightDone) begin
          res_d   = iFightCount;
          tmo_d   = 1'b0;
          irq_d   = 1'b1;
          mrst_d  = 1'b1;
          state_d = ST_REPORT;
        end else if (iNewFrame && hit_term) begin
          res_d   = '1;
          tmo_d   = 1'b1;
          irq_d   = 1'b1;
          mrst_d  = 1'b1;
          state_d = ST_REPORT;
        end else if (accept && legal) begin
          pend_d  = mtl_mode_e'(iReqMode);
          mrst_d  = 1'b1;
          cnt_clr = 1'b1;
          cnt_inc = 1'b0;
          state_d = ST_PENDING;
        end
      end

      ST_REPORT: begin
        mrst_d = 1'b1;
        if (iIrqAck) begin
          irq_d   = 1'b0;
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      state_q <= ST_IDLE;
      pend_q  <= MODE_LOAD;
      mode_q  <= MODE_LOAD;
      mrst_q  <= 1'b1;
      irq_q   <= 1'b0;
      tmo_q   <= 1'b0;
      res_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      mode_q  <= mode_d;
      mrst_q  <= mrst_d;
      irq_q   <= irq_d;
      tmo_q   <= tmo_d;
      res_q   <= res_d;
      err_q   <= err_d;
    end
  end

  assign oReqReady   = req_ready;
  assign oReqErr     = err_q;
  assign oMtlMode    = mode_q;
  assign oMtlReset   = mrst_q;
  assign oIrq        = irq_q;
  assign oTimeout    = tmo_q;
  assign oResultTime = res_q;
  assign oState      = state_q;

endmodule

// File: doc/mtl_mode_scheduler.md
Name: mtl_mode_scheduler

Overview:
Sequences the MTL display controller's operating mode on behalf of the host interface (PIC32 register path).
- Accepts mode-change requests through a valid/ready handshake and applies each one only at a frame boundary.
- Arms and releases the fight-game logic (mtl_reset) across whole frames.
- Runs the fight-round timeout, captures the fight time, and raises an interrupt with acknowledge.
- Sits between the host register block and mtl_controller, driving its mtl_mode and mtl_reset inputs.

Parameters:
ARM_FRAMES, 2, number of iNewFrame pulses for which oMtlReset stays high after fight mode is applied (legal 1..15)
TIMEOUT_FRAMES, 1800, frames allowed in FIGHT_RUN before a forced end (about 30 s at 59.5 Hz)
CNT_W, 32, width of the fight-time counter and result

Ports:
iCLK  in  1  pixel/LCD clock
iRST  in  1  asynchronous active-high reset
iNewFrame  in  1  one-cycle pulse at x_cnt=0, y_cnt=0 (from mtl_controller)
iReqValid  in  1  host mode request valid
oReqReady  out  1  scheduler can accept a request
iReqMode  in  4  requested mode code
oReqErr  out  1  one-cycle pulse: illegal mode code dropped
oMtlMode  out  4  mode driven to mtl_controller
oMtlReset  out  1  fight-logic reset driven to mtl_controller
iFightDone  in  1  level, mtl_controller mtl_irq (all cases hit)
iFightCount  in  CNT_W  mtl_controller mtl_counter
oResultTime  out  CNT_W  captured fight time
oTimeout  out  1  last round ended by timeout
oIrq  out  1  round-finished interrupt to host
iIrqAck  in  1  host acknowledge
oState  out  3  current state code (debug/host readback)

Behaviour:
Reset values (any time iRST is high, including mid-operation):
- State IDLE, oMtlMode=MODE_LOAD (4'b0001), oMtlReset=1, oIrq=0, oTimeout=0, oResultTime=0, oReqErr=0.
- Frame counter cleared.
- No pending request survives reset.

Legal mode codes: FIGHT=0, LOAD=1, MAP_P0=2, MAP_P1=3. Codes 4..15 are illegal.

Handshake:
- A transfer occurs on a cycle where iReqValid and oReqReady are both high.
- oReqReady=1 only in IDLE and FIGHT_RUN; it is combinational from the state.
- Illegal code: the transfer completes, oReqErr pulses on the next cycle, and state and outputs are unchanged.

IDLE:
- Legal request: latch the code into pend_mode and go to PENDING.
- A request on the same cycle as iNewFrame is not applied at that pulse; it waits for the next one.

PENDING:
- On the edge where iNewFrame=1: oMtlMode <= pend_mode, effective the next cycle.
- If pend_mode=FIGHT: go to FIGHT_ARM, frame counter=1 (the applying pulse counts as the first).
- Otherwise: go to IDLE, oMtlReset stays 1.
- Requesting the current mode still passes through PENDING; for FIGHT this re-arms the round.

FIGHT_ARM:
- oMtlReset=1.
- Each iNewFrame increments the frame counter.
- On the edge of the pulse where the counter already equals ARM_FRAMES: oMtlReset <= 0, counter cleared, go to FIGHT_RUN.
- Net effect: oMtlReset is guaranteed high at ARM_FRAMES consecutive frame starts.

FIGHT_RUN:
- oMtlReset=0; the counter counts iNewFrame pulses.
- iFightDone=1: oResultTime <= iFightCount, oTimeout <= 0, oIrq <= 1, go to REPORT.
- Otherwise, if an iNewFrame pulse brings the counter to TIMEOUT_FRAMES: oResultTime <= all ones, oTimeout <= 1, oIrq <= 1, go to REPORT.
- iFightDone and timeout on the same cycle: done wins.
- Legal request accepted here aborts the round: oMtlReset <= 1 at once, no irq, go to PENDING.
- Illegal request accepted here: oReqErr pulse, round continues.

REPORT:
- oReqReady=0, oMtlReset <= 1 on entry.
- oIrq holds until iIrqAck=1; on that edge oIrq <= 0 and go to IDLE. oMtlMode stays FIGHT.
- oResultTime and oTimeout hold until the next REPORT entry or reset.
- iIrqAck outside REPORT is ignored.

Counter width: 11 bits, saturating, sufficient for TIMEOUT_FRAMES up to 2047.

oState codes: IDLE=0, PENDING=1, FIGHT_ARM=2, FIGHT_RUN=3, REPORT=4.

All outputs are registered except oReqReady.

Decomposition:
- Package mtl_pkg: the mode-code enum (FIGHT/LOAD/MAP_P0/MAP_P1), the state enum with the codes above, and a helper function is_legal_mode.
- One sub-module, mtl_frame_counter: counts iNewFrame pulses, with synchronous clear, saturation, and a terminal-compare output. It is reused for both ARM_FRAMES and TIMEOUT_FRAMES.

Test Plan:
1. Reset release, then request MAP_P1 (3) mid-frame -> oMtlMode stays 1 until the cycle after the next iNewFrame, then reads 3; oMtlReset=1 throughout; oState returns to 0.
2. Request FIGHT -> oMtlReset high at 2 frame starts, low from the cycle after the 2nd pulse; iFightDone with iFightCount=0x1234 -> oResultTime=0x1234, oIrq=1, oTimeout=0; iIrqAck -> oIrq=0, oState=0, oMtlReset=1.
3. FIGHT with iFightDone held low, TIMEOUT_FRAMES=4 -> oIrq rises on the edge of the 4th frame pulse in FIGHT_RUN; oResultTime=0xFFFFFFFF, oTimeout=1.
4. Request code 7 in IDLE -> oReqErr one-cycle pulse, oMtlMode and oState unchanged; request LOAD during FIGHT_RUN -> oMtlReset=1 next cycle, no oIrq, oMtlMode=1 after the next frame.
5. iFightDone and timeout pulse on the same cycle -> oTimeout=0 and the captured count is used; iReqValid during REPORT -> oReqReady=0 and the request is not taken.
6. Assert iRST during FIGHT_RUN -> oMtlMode=1, oMtlReset=1, oIrq=0 immediately (asynchronous), oState=0.
